// File: rtl/button_event_decoder.sv
// Classifies debounced push-button pulses into short, long and double press events.
// Optional auto-repeat in the long-held state is enabled by BUTTON_EVENT_DECODER_AUTOREPEAT_EN.
module button_event_decoder #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned LONG_CYCLES   = 50000,
  parameter int unsigned GAP_CYCLES    = 20000,
  parameter int unsigned REPEAT_CYCLES = 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pb_down_i,
  input  logic pb_up_i,
  output logic short_press_o,
  output logic long_press_o,
  output logic double_press_o,
  output logic repeat_press_o,
  output logic busy_o
);

  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("button_event_decoder: cycle parameters must be at least 2");
  end

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
`ifdef BUTTON_EVENT_DECODER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StPressed,
    StWaitGap,
    StSecond,
    StLongHeld
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic             down, up;

  // Simultaneous down and up is illegal and treated as no edge at all.
  assign down = pb_down_i & ~pb_up_i;
  assign up   = pb_up_i & ~pb_down_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (down) state_d = StPressed;
      end
      StPressed: begin
        if (up) begin
          state_d = StWaitGap;
        end else if (cnt_q == LongLast) begin
          long_d  = 1'b1;
          state_d = StLongHeld;
        end
      end
      StWaitGap: begin
        if (down) begin
          state_d = StSecond;
        end else if (cnt_q == GapLast) begin
          short_d = 1'b1;
          state_d = StIdle;
        end
      end
      StSecond: begin
        if (up) begin
          double_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StLongHeld: begin
        if (up) begin
          state_d = StIdle;
        end
`ifdef BUTTON_EVENT_DECODER_AUTOREPEAT_EN
        else if (cnt_q == RepeatLast) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
`else
        cnt_d = '0;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press_o  = short_q;
  assign long_press_o   = long_q;
  assign double_press_o = double_q;
`ifdef BUTTON_EVENT_DECODER_AUTOREPEAT_EN
  assign repeat_press_o = repeat_q;
`else
  assign repeat_press_o = 1'b0;
`endif
  assign busy_o         = busy_q;

endmodule
